dkey_schedule: RTL and testbench

//  AES-128 decryption key schedule; sits directly upstream of dfirstround and the later inverse rounds.
//  On start, expands cipher_key forward into round keys 0..NR, one round per clock, and stores them.
//  It then serves the keys in reverse order (NR first, 0 last).
//  rk_out at rk_idx=NR is the inkey of dfirstround; rk_next steps the sequence for each following round.

---
 rtl/dkey_pkg.sv | 61 ++++++
 rtl/dkey_step.sv | 31 +++
 rtl/dkey_schedule.sv | 136 +++++++++++++
 tb/tb_dkey_schedule.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dkey_pkg.sv
// Shared definitions for the AES-128 decryption key schedule:
// round count, key width, FSM encoding, round constants and forward S-box.
package dkey_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  // Index of the last round key, sized to the index registers.
  localparam logic [3:0] LAST_RK = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } dkey_state_e;

  // Forward AES S-box, entry 0 first.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup (encryption direction; key expansion never uses the inverse box).
  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for expansion round r (1..10); unused indices give zero.
  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/dkey_step.sv
// One AES-128 key-expansion round: derives round key r from round key r-1.
module dkey_step
  import dkey_pkg::*;
(
  input  logic [127:0] prev_key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] next_key_o
);

  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic [31:0] rot_s, sub_s, tmp_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;

  // Word chain: each new word folds in the previous new word.
  always_comb begin
    w0_s  = prev_key_i[127:96];
    w1_s  = prev_key_i[95:64];
    w2_s  = prev_key_i[63:32];
    w3_s  = prev_key_i[31:0];
    rot_s = {w3_s[23:0], w3_s[31:24]};
    sub_s = {sbox_fwd(rot_s[31:24]), sbox_fwd(rot_s[23:16]),
             sbox_fwd(rot_s[15:8]),  sbox_fwd(rot_s[7:0])};
    tmp_s = sub_s ^ {rcon_i, 24'h000000};
    n0_s  = w0_s ^ tmp_s;
    n1_s  = w1_s ^ n0_s;
    n2_s  = w2_s ^ n1_s;
    n3_s  = w3_s ^ n2_s;
    next_key_o = {n0_s, n1_s, n2_s, n3_s};
  end

endmodule

// File: rtl/dkey_schedule.sv
// AES-128 decryption key schedule: expands the cipher key forward into
// round keys 0..10 (one per clock) and then presents them from 10 down to 0.
module dkey_schedule
  import dkey_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] cipher_key_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_next_i,
  output logic [127:0] rk_out_o,
  output logic [3:0]   rk_idx_o,
  output logic         done_o
);

  dkey_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;

  // Key store deliberately has no reset: contents are only meaningful in SERVE.
  logic [KEY_W-1:0] mem_q [0:NR];

  logic             mem_we_s;
  logic [3:0]       mem_waddr_s;
  logic [KEY_W-1:0] mem_wdata_s;
  logic [3:0]       prev_idx_s;
  logic [KEY_W-1:0] prev_key_s;
  logic [KEY_W-1:0] next_key_s;

  // Source for the expansion round: the key written on the previous edge.
  always_comb begin
    if (cnt_q == 4'd0) begin
      prev_idx_s = 4'd0;
    end else begin
      prev_idx_s = cnt_q - 4'd1;
    end
    prev_key_s = mem_q[prev_idx_s];
  end

  dkey_step u_step (
    .prev_key_i (prev_key_s),
    .rcon_i     (rcon_f(cnt_q)),
    .next_key_o (next_key_s)
  );

  // Next-state logic: accept start, run the expansion, then walk keys downward.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_q;
    mem_wdata_s = next_key_s;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = 4'd0;
          mem_wdata_s = cipher_key_i;
          cnt_d       = 4'd1;
          state_d     = ST_EXPAND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        mem_we_s = 1'b1;
        if (cnt_q == LAST_RK) begin
          cnt_d   = 4'd0;
          idx_d   = LAST_RK;
          state_d = ST_SERVE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SERVE: begin
        if (rk_next_i) begin
          if (idx_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q - 4'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Control registers; reset overrides start and rk_next in every state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Key store write port; writes are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Output decode from registered state; rk_out follows idx with no extra latency.
  always_comb begin
    busy_o     = (state_q == ST_EXPAND);
    rk_valid_o = (state_q == ST_SERVE);
    done_o     = done_q;
    if (state_q == ST_SERVE) begin
      rk_out_o = mem_q[idx_q];
      rk_idx_o = idx_q;
    end else begin
      rk_out_o = 128'h0;
      rk_idx_o = 4'd0;
    end
  end

endmodule

// File: tb/tb_dkey_schedule.sv
// Directed bench for dkey_schedule using the FIPS-197 A.1 key expansion.
module tb_dkey_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_next;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] rk_tab [0:10];
  logic [127:0] other_key;

  dkey_schedule dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cipher_key_i (cipher_key),
    .busy_o       (busy),
    .rk_valid_o   (rk_valid),
    .rk_next_i    (rk_next),
    .rk_out_o     (rk_out),
    .rk_idx_o     (rk_idx),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check every output against one expected tuple.
  task automatic chk_all(input string tag, input logic e_busy, input logic e_valid,
                         input logic [3:0] e_idx, input logic [127:0] e_key, input logic e_done);
    chk({tag, "/busy"},     {127'h0, busy},     {127'h0, e_busy});
    chk({tag, "/rk_valid"}, {127'h0, rk_valid}, {127'h0, e_valid});
    chk({tag, "/rk_idx"},   {124'h0, rk_idx},   {124'h0, e_idx});
    chk({tag, "/rk_out"},   rk_out,             e_key);
    chk({tag, "/done"},     {127'h0, done},     {127'h0, e_done});
  endtask

  initial begin
    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    other_key  = 128'h000102030405060708090a0b0c0d0e0f;

    rst        = 1'b1;
    start      = 1'b0;
    rk_next    = 1'b0;
    cipher_key = 128'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all("reset", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0);

    // Scenario 1 + 4: A.1 key, start re-asserted with another key at EXPAND cycle 4.
    start      = 1'b1;
    cipher_key = rk_tab[0];
    tick();                                   // edge N
    start      = 1'b0;
    cipher_key = other_key;
    chk_all("exp_first", 1'b1, 1'b0, 4'd0, 128'h0, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      start = (e == 4);
      tick();                                 // edge N+e
    end
    start = 1'b0;
    chk_all("exp_n9", 1'b1, 1'b0, 4'd0, 128'h0, 1'b0);
    tick();                                   // edge N+10
    chk_all("serve_10", 1'b0, 1'b1, 4'd10, rk_tab[10], 1'b0);

    // Scenario 4: start in SERVE ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("serve_start_ign", 1'b0, 1'b1, 4'd10, rk_tab[10], 1'b0);

    // Scenario 2: step through keys 9..0 one pulse at a time, with a hold check.
    for (int k = 9; k >= 0; k--) begin
      rk_next = 1'b1;
      tick();
      rk_next = 1'b0;
      chk_all($sformatf("step_%0d", k), 1'b0, 1'b1, 4'(k), rk_tab[k], 1'b0);
      if (k == 5) begin
        tick();
        chk_all("hold_5", 1'b0, 1'b1, 4'd5, rk_tab[5], 1'b0);
      end
    end

    // Scenario 3: consume key 0.
    rk_next = 1'b1;
    tick();
    rk_next = 1'b0;
    chk_all("done_pulse", 1'b0, 1'b0, 4'd0, 128'h0, 1'b1);
    tick();
    chk_all("after_done", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0);

    // Scenario 5: reset at EXPAND cycle 5.
    start      = 1'b1;
    cipher_key = other_key;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    chk_all("exp_c5", 1'b1, 1'b0, 4'd0, 128'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_rst", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0);
    tick();
    chk_all("mid_rst_idle", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0);

    // Fresh start reproduces scenario 1.
    start      = 1'b1;
    cipher_key = rk_tab[0];
    tick();
    start = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    chk_all("rerun_n9", 1'b1, 1'b0, 4'd0, 128'h0, 1'b0);
    tick();
    chk_all("rerun_10", 1'b0, 1'b1, 4'd10, rk_tab[10], 1'b0);

    // Scenario 6: rk_next held high from the rk_valid rise.
    rk_next = 1'b1;
    for (int k = 9; k >= 0; k--) begin
      tick();
      chk_all($sformatf("burst_%0d", k), 1'b0, 1'b1, 4'(k), rk_tab[k], 1'b0);
    end
    tick();
    chk_all("burst_done", 1'b0, 1'b0, 4'd0, 128'h0, 1'b1);
    tick();
    chk_all("burst_idle", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0);
    rk_next = 1'b0;
    tick();
    chk_all("final_idle", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
